// File: rtl/snn_ctrl.sv
// snn_ctrl - top-level sequencer for the SNN digit classifier.
//
// Collects a binary image from UART bytes, writes it pixel-by-pixel into the
// 1-bit input RAM, kicks the SNN core, waits for its result and reports the
// classified digit on the LEDs and as one ASCII character on the UART TX.
//
// Ports:
//   clk       system clock, rising edge
//   rst       synchronous active-high reset; abandons any partial frame
//   rx_rdy    one-cycle strobe, rx_data holds a new byte
//   rx_data   received byte, pixels LSB first
//   tx_rdy    UART transmitter idle
//   tx_start  one-cycle request to transmit tx_data
//   tx_data   result character (ASCII digit, or '?' when out of range)
//   ram_data  pixel bit written to the input RAM
//   ram_addr  pixel address
//   ram_we    input-RAM write enable
//   start     one-cycle start pulse to the SNN core
//   done      SNN core finished, digit valid in the same cycle
//   digit     classification result
//   led       {busy, 3'b000, digit_reg}
module snn_ctrl #(
  parameter int          NUM_BYTES  = 98,
  parameter int          ADDR_W     = 10,
  parameter logic [7:0]  ASCII_BASE = 8'h30
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_rdy,
  input  logic [7:0]        rx_data,
  input  logic              tx_rdy,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  output logic              ram_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic              start,
  input  logic              done,
  input  logic [3:0]        digit,
  output logic [7:0]        led
);

  localparam logic [2:0] S_LOAD  = 3'd0;
  localparam logic [2:0] S_WRITE = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_TX    = 3'd4;

  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(NUM_BYTES * 8);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  // Digits above 9 have no ASCII digit, so they are reported as '?'.
  function automatic logic [7:0] digit_char(input logic [3:0] d);
    if (d > 4'd9) begin
      return 8'h3F;
    end
    return ASCII_BASE + {4'b0000, d};
  endfunction

  logic [2:0]        state,     state_n;
  logic [7:0]        shreg,     shreg_n;
  logic [2:0]        bit_cnt,   bit_cnt_n;
  logic [ADDR_W-1:0] ptr,       ptr_n;
  logic [3:0]        digit_reg, digit_n;

  logic              we_n, data_n, start_n, tx_start_n, busy_n;
  logic [ADDR_W-1:0] addr_n;
  logic [7:0]        tx_data_n;

  // Next-state and next-output decode. Outputs are registered, so each write
  // is prepared one cycle ahead: the byte-accept edge already launches bit 0,
  // and the WRITE cycle showing bit 7 launches no further write.
  always_comb begin
    state_n    = state;
    shreg_n    = shreg;
    bit_cnt_n  = bit_cnt;
    ptr_n      = ptr;
    digit_n    = digit_reg;
    we_n       = 1'b0;
    data_n     = ram_data;
    addr_n     = ram_addr;
    start_n    = 1'b0;
    tx_start_n = 1'b0;
    tx_data_n  = tx_data;

    case (state)
      S_LOAD: begin
        if (rx_rdy) begin
          // Bit 0 goes straight out; the register keeps bits 1..7.
          shreg_n   = {1'b0, rx_data[7:1]};
          data_n    = rx_data[0];
          we_n      = 1'b1;
          addr_n    = ptr;
          ptr_n     = ptr + PTR_ONE;
          bit_cnt_n = 3'd0;
          state_n   = S_WRITE;
        end
      end

      S_WRITE: begin
        if (bit_cnt == 3'd7) begin
          if (ptr == LAST_PTR) begin
            start_n = 1'b1;
            state_n = S_START;
          end else begin
            state_n = S_LOAD;
          end
        end else begin
          we_n      = 1'b1;
          data_n    = shreg[0];
          shreg_n   = {1'b0, shreg[7:1]};
          addr_n    = ptr;
          ptr_n     = ptr + PTR_ONE;
          bit_cnt_n = bit_cnt + 3'd1;
        end
      end

      S_START: begin
        ptr_n   = '0;
        state_n = S_WAIT;
      end

      S_WAIT: begin
        if (done) begin
          digit_n   = digit;
          tx_data_n = digit_char(digit);
          state_n   = S_TX;
        end
      end

      S_TX: begin
        if (tx_rdy) begin
          tx_start_n = 1'b1;
          state_n    = S_LOAD;
        end
      end

      default: begin
        state_n = S_LOAD;
      end
    endcase

    // Idle only while waiting for the first byte of a frame.
    busy_n = !((state_n == S_LOAD) && (ptr_n == '0));
  end

  // Register boundary: state, datapath and all outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_LOAD;
      shreg     <= '0;
      bit_cnt   <= '0;
      ptr       <= '0;
      digit_reg <= '0;
      ram_we    <= 1'b0;
      ram_data  <= 1'b0;
      ram_addr  <= '0;
      start     <= 1'b0;
      tx_start  <= 1'b0;
      tx_data   <= '0;
      led       <= '0;
    end else begin
      state     <= state_n;
      shreg     <= shreg_n;
      bit_cnt   <= bit_cnt_n;
      ptr       <= ptr_n;
      digit_reg <= digit_n;
      ram_we    <= we_n;
      ram_data  <= data_n;
      ram_addr  <= addr_n;
      start     <= start_n;
      tx_start  <= tx_start_n;
      tx_data   <= tx_data_n;
      led       <= {busy_n, 3'b000, digit_n};
    end
  end

endmodule

// File: tb/tb_snn_ctrl.sv
// Testbench for snn_ctrl: directed scenarios with hand-computed expectations.
module tb_snn_ctrl;

  localparam int NB = 98;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_rdy;
  logic [7:0] rx_data;
  logic       tx_rdy;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       ram_data;
  logic [9:0] ram_addr;
  logic       ram_we;
  logic       start;
  logic       done;
  logic [3:0] digit;
  logic [7:0] led;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  snn_ctrl #(
    .NUM_BYTES (NB),
    .ADDR_W    (10),
    .ASCII_BASE(8'h30)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .rx_rdy  (rx_rdy),
    .rx_data (rx_data),
    .tx_rdy  (tx_rdy),
    .tx_start(tx_start),
    .tx_data (tx_data),
    .ram_data(ram_data),
    .ram_addr(ram_addr),
    .ram_we  (ram_we),
    .start   (start),
    .done    (done),
    .digit   (digit),
    .led     (led)
  );

  // Activity recorder: cumulative counts only, scenarios take differences.
  int         cyc         = 0;
  int         wr_total    = 0;
  int         start_total = 0;
  int         txs_total   = 0;
  int         addr_err    = 0;
  int         last_we_cyc = 0;
  int         start_gap   = 0;
  logic [9:0] exp_addr    = 10'd0;
  logic [9:0] last_wr_addr = 10'd0;
  logic       wr_bit [0:1023];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (ram_we) begin
      wr_total          <= wr_total + 1;
      wr_bit[ram_addr]  <= ram_data;
      last_wr_addr      <= ram_addr;
      last_we_cyc       <= cyc;
      if (ram_addr !== exp_addr) addr_err <= addr_err + 1;
      exp_addr          <= ram_addr + 10'd1;
    end
    if (start) begin
      start_total <= start_total + 1;
      start_gap   <= cyc - last_we_cyc;
    end
    if (tx_start) txs_total <= txs_total + 1;
    if (rst || start) exp_addr <= 10'd0;
  end

  int start_snap = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one byte; returns the address of its first write and leaves the
  // bench in the first cycle where the next byte may be accepted.
  task automatic send_byte(input logic [7:0] b, output logic [9:0] a0);
    rx_data = b;
    rx_rdy  = 1'b1;
    tick();
    a0     = ram_addr;
    rx_rdy = 1'b0;
    repeat (8) tick();
  endtask

  task automatic test_reset();
    logic [7:0] pat;
    rst = 1'b1; rx_rdy = 1'b0; rx_data = 8'h00; tx_rdy = 1'b1; done = 1'b0; digit = 4'd0;
    tick(); tick();
    total++;
    if ({tx_start, tx_data, ram_data, ram_addr, ram_we, start, led} !== 30'd0) begin
      bad++;
      $display("FAIL reset_outputs: tx_start=%b tx_data=%h ram_data=%b ram_addr=%0d ram_we=%b start=%b led=%h, want all 0",
               tx_start, tx_data, ram_data, ram_addr, ram_we, start, led);
    end
    rst = 1'b0;
    tick();
    pat     = 8'hA5;
    rx_data = pat;
    rx_rdy  = 1'b1;
    tick();
    rx_rdy = 1'b0;
    for (int j = 0; j < 8; j++) begin
      total++;
      if (ram_we !== 1'b1 || ram_addr !== 10'(j) || ram_data !== pat[j]) begin
        bad++;
        $display("FAIL first_byte_bit%0d: we=%b addr=%0d data=%b, want we=1 addr=%0d data=%b",
                 j, ram_we, ram_addr, ram_data, j, pat[j]);
      end
      tick();
    end
    total++;
    if (ram_we !== 1'b0 || start !== 1'b0) begin
      bad++;
      $display("FAIL first_byte_end: we=%b start=%b, want 0 0", ram_we, start);
    end
    total++;
    if (led !== 8'h80) begin
      bad++;
      $display("FAIL busy_mid_frame: led=%h want 80", led);
    end
  endtask

  task automatic test_dropped_byte();
    int         w0, ae0;
    logic [9:0] a0;
    rst = 1'b1; tick(); rst = 1'b0; tick();
    w0  = wr_total;
    ae0 = addr_err;
    rx_data = 8'h3C;
    rx_rdy  = 1'b1;
    tick();
    rx_rdy = 1'b0;
    tick(); tick(); tick();
    rx_data = 8'hFF;
    rx_rdy  = 1'b1;
    tick();
    rx_rdy = 1'b0;
    repeat (4) tick();
    total++;
    if (wr_total - w0 !== 8) begin
      bad++;
      $display("FAIL dropped_write_count: got %0d writes, want 8", wr_total - w0);
    end
    send_byte(8'h00, a0);
    total++;
    if (a0 !== 10'd8) begin
      bad++;
      $display("FAIL dropped_pointer: next byte starts at %0d, want 8", a0);
    end
    total++;
    if (wr_total - w0 !== 16 || addr_err - ae0 !== 0) begin
      bad++;
      $display("FAIL dropped_contiguity: writes=%0d addr_errors=%0d, want 16 0",
               wr_total - w0, addr_err - ae0);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [9:0] a0;
    rst = 1'b1; tick(); rst = 1'b0; tick();
    start_snap = start_total;
    for (int k = 0; k < 40; k++) send_byte(8'hFF, a0);
    rx_data = 8'hFF;
    rx_rdy  = 1'b1;
    tick();
    rx_rdy = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick(); tick();
    total++;
    if ({tx_start, tx_data, ram_data, ram_addr, ram_we, start, led} !== 30'd0) begin
      bad++;
      $display("FAIL midframe_reset_outputs: tx_start=%b tx_data=%h ram_data=%b ram_addr=%0d ram_we=%b start=%b led=%h, want all 0",
               tx_start, tx_data, ram_data, ram_addr, ram_we, start, led);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_full_frame();
    int         w0, ae0, t0, errs;
    logic [9:0] a0;
    logic [7:0] kb;
    w0  = wr_total;
    ae0 = addr_err;
    t0  = txs_total;
    for (int k = 0; k < NB; k++) begin
      send_byte(8'(k), a0);
      if (k == 0) begin
        total++;
        if (a0 !== 10'd0) begin
          bad++;
          $display("FAIL frame_first_addr: got %0d want 0", a0);
        end
      end
    end
    total++;
    if (start !== 1'b1) begin
      bad++;
      $display("FAIL start_after_last_byte: start=%b want 1", start);
    end
    tick();
    total++;
    if (start !== 1'b0 || start_gap !== 1 || start_total - start_snap !== 1) begin
      bad++;
      $display("FAIL start_pulse: start=%b gap=%0d pulses=%0d, want 0 1 1",
               start, start_gap, start_total - start_snap);
    end
    total++;
    if (wr_total - w0 !== 784 || addr_err - ae0 !== 0 || last_wr_addr !== 10'd783) begin
      bad++;
      $display("FAIL frame_writes: count=%0d addr_errors=%0d last=%0d, want 784 0 783",
               wr_total - w0, addr_err - ae0, last_wr_addr);
    end
    errs = 0;
    for (int k = 0; k < NB; k++) begin
      kb = 8'(k);
      for (int i = 0; i < 8; i++) begin
        if (wr_bit[8*k+i] !== kb[i]) errs++;
      end
    end
    total++;
    if (errs !== 0) begin
      bad++;
      $display("FAIL frame_pixels: %0d wrong pixels, want 0", errs);
    end
    tx_rdy = 1'b1;
    repeat (3) tick();
    total++;
    if (tx_start !== 1'b0 || led !== 8'h80) begin
      bad++;
      $display("FAIL waiting_core: tx_start=%b led=%h, want 0 80", tx_start, led);
    end
    done  = 1'b1;
    digit = 4'd7;
    tick();
    done  = 1'b0;
    digit = 4'd0;
    total++;
    if (led !== 8'h87 || tx_start !== 1'b0) begin
      bad++;
      $display("FAIL result_led: led=%h tx_start=%b, want 87 0", led, tx_start);
    end
    tick();
    total++;
    if (tx_start !== 1'b1 || tx_data !== 8'h37 || led !== 8'h07) begin
      bad++;
      $display("FAIL result_tx: tx_start=%b tx_data=%h led=%h, want 1 37 07", tx_start, tx_data, led);
    end
    tick();
    total++;
    if (tx_start !== 1'b0 || txs_total - t0 !== 1 || start_total - start_snap !== 1) begin
      bad++;
      $display("FAIL single_pulses: tx_start=%b tx_pulses=%0d start_pulses=%0d, want 0 1 1",
               tx_start, txs_total - t0, start_total - start_snap);
    end
  endtask

  task automatic test_tx_backpressure();
    int         t0, bad_cyc;
    logic [9:0] a0;
    t0 = txs_total;
    for (int k = 0; k < NB; k++) send_byte(8'(k * 3), a0);
    tx_rdy = 1'b0;
    tick();
    done  = 1'b1;
    digit = 4'd12;
    tick();
    done  = 1'b0;
    digit = 4'd0;
    total++;
    if (led !== 8'h8C || tx_data !== 8'h3F) begin
      bad++;
      $display("FAIL clamp_result: led=%h tx_data=%h, want 8c 3f", led, tx_data);
    end
    bad_cyc = 0;
    repeat (50) begin
      if (tx_start !== 1'b0 || tx_data !== 8'h3F) bad_cyc++;
      tick();
    end
    total++;
    if (bad_cyc !== 0 || txs_total - t0 !== 0) begin
      bad++;
      $display("FAIL backpressure_hold: bad_cycles=%0d tx_pulses=%0d, want 0 0", bad_cyc, txs_total - t0);
    end
    tx_rdy = 1'b1;
    tick();
    total++;
    if (tx_start !== 1'b1 || tx_data !== 8'h3F) begin
      bad++;
      $display("FAIL backpressure_release: tx_start=%b tx_data=%h, want 1 3f", tx_start, tx_data);
    end
    tick(); tick();
    total++;
    if (tx_start !== 1'b0 || txs_total - t0 !== 1) begin
      bad++;
      $display("FAIL backpressure_single: tx_start=%b tx_pulses=%0d, want 0 1", tx_start, txs_total - t0);
    end
  endtask

  task automatic test_spurious_done();
    int         t0;
    logic [9:0] a0;
    t0    = txs_total;
    done  = 1'b1;
    digit = 4'd5;
    repeat (3) tick();
    done  = 1'b0;
    digit = 4'd0;
    tick();
    total++;
    if (led !== 8'h0C || tx_start !== 1'b0 || txs_total - t0 !== 0) begin
      bad++;
      $display("FAIL spurious_done_idle: led=%h tx_start=%b tx_pulses=%0d, want 0c 0 0",
               led, tx_start, txs_total - t0);
    end
    send_byte(8'h81, a0);
    total++;
    if (a0 !== 10'd0 || led !== 8'h8C) begin
      bad++;
      $display("FAIL after_spurious_done: first_addr=%0d led=%h, want 0 8c", a0, led);
    end
  endtask

  initial begin
    test_reset();
    test_dropped_byte();
    test_reset_mid_frame();
    test_full_frame();
    test_tx_backpressure();
    test_spurious_done();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/snn_ctrl.md
# snn_ctrl

Top-level sequencer for the SNN digit classifier. It assembles a 784-pixel binary image from 98 UART bytes and writes it bit-by-bit into the 1-bit-wide input RAM. It then pulses `start` to the SNN core, waits for `done`, and reports the classified digit on the LEDs and as one ASCII byte on the UART transmitter. It sits between the UART RX/TX pair, the input-unit RAM and the SNN core, replacing the direct RX→TX loopback.

## Interface
- `NUM_BYTES`, 98, image bytes per frame (`NUM_BYTES*8` pixels).
- `ADDR_W`, 10, input-RAM address width.
- `ASCII_BASE`, 8'h30, added to the digit to form the TX character.

- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `rx_rdy`  in  1  one-cycle strobe: `rx_data` holds a new byte.
- `rx_data`  in  8  received byte; pixel order is LSB first.
- `tx_rdy`  in  1  UART transmitter idle.
- `tx_start`  out  1  one-cycle request to transmit `tx_data`.
- `tx_data`  out  8  result character.
- `ram_data`  out  1  pixel bit written to the input RAM.
- `ram_addr`  out  ADDR_W  pixel address.
- `ram_we`  out  1  input-RAM write enable.
- `start`  out  1  one-cycle start pulse to the SNN core.
- `done`  in  1  SNN core finished; `digit` valid in the same cycle.
- `digit`  in  4  classification result.
- `led`  out  8  `{busy, 3'b000, digit_reg}`.

## Operation
- States: LOAD, WRITE, START, WAIT, TX.
- **LOAD:** wait for `rx_rdy`.
  - On `rx_rdy`: latch `rx_data` into an 8-bit shift register, clear the bit counter, go to WRITE.
- **WRITE:** runs 8 cycles. Each cycle:
  - `ram_we`=1, `ram_data`=shreg[0], `ram_addr`=pixel pointer.
  - Shift the register right; increment the pointer and the bit counter.
  - After bit 7: if the pointer has reached `NUM_BYTES*8`, go to START; else return to LOAD.
- Byte k, bit i is always written to address 8k+i. The pointer never wraps within a frame.
- **START:** `start`=1 for exactly one cycle; the pointer clears to 0; go to WAIT.
- **WAIT:** on `done`, latch `digit` into `digit_reg` and go to TX.
- **TX:** when `tx_rdy`=1, pulse `tx_start` and go to LOAD.
  - `tx_data` = `ASCII_BASE` + `digit_reg`.
  - If `digit_reg` > 9, `tx_data` = 8'h3F ('?').
- `busy`=1 in every state except LOAD when the pointer is 0, i.e. from the first received byte until the result has been sent.
- Boundary behaviour:
  - `rx_rdy` while in WRITE, START, WAIT or TX: byte dropped; no RAM write; pointer unchanged.
  - `done` outside WAIT: ignored.
  - `tx_rdy` low in TX: hold TX indefinitely, `tx_data` stable.
  - `rst` in any state, including mid-frame: the frame is abandoned. Pointer, counter, `digit_reg` and all outputs clear. No `start` or `tx_start` is issued for the partial frame. The next byte after reset is pixel 0.

## Timing
- All outputs are registered.
- Reset values: `tx_start`=0, `tx_data`=0, `ram_data`=0, `ram_addr`=0, `ram_we`=0, `start`=0, `led`=0; state LOAD.
- `rx_rdy` sampled at cycle N → `ram_we` high in cycles N+1..N+8, at addresses 8k..8k+7.
- The next byte is accepted from cycle N+9.
- Last byte: final write at N+8, `start` high at N+9.
- `done` sampled at cycle D → `digit_reg` and `led` update at D+1.
- `tx_start` is high at D+2 if `tx_rdy` was 1 at D+1; otherwise it is high one cycle after `tx_rdy` is first sampled high.
- `tx_start` is high for exactly one cycle per frame, and `start` for exactly one cycle per frame.
- Minimum frame time: `NUM_BYTES`·9 cycles + core latency + 2.

## Test plan
- **Reset:** assert `rst` 2 cycles → all outputs 0. The first `rx_rdy` with 8'hA5 writes bits 1,0,1,0,0,1,0,1 to addresses 0..7 in cycles N+1..N+8.
- **Full frame:** send 98 bytes (byte k = k) → 784 writes with contiguous addresses 0..783 and `start` high one cycle after address 783 is written. Stub `done` with `digit`=7 → `led`=8'h87, then `tx_start` with `tx_data`=8'h37, then `led`=8'h07.
- **Dropped byte:** `rx_rdy` during the 4th WRITE cycle → no extra writes; the pointer is 8 after the byte completes.
- **TX back-pressure / clamp:** hold `tx_rdy`=0 for 50 cycles in TX → no `tx_start`, `tx_data` stable. Release → a single `tx_start` pulse. With `digit`=12 → `tx_data`=8'h3F.
- **Reset mid-frame:** assert `rst` after 40 bytes, then send a full frame → writes start at address 0; exactly one `start` pulse.
- **Spurious `done`:** assert `done` in LOAD → no `tx_start`; `digit_reg` unchanged.
